// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, write-back data select, decode bypass flags and retire counter.
module writeback_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regWrite,
    input  logic [4:0]        in_rd,
    input  logic [1:0]        in_wbSel,
    input  logic [1:0]        in_memSize,
    input  logic              in_memUnsigned,
    input  logic [1:0]        in_addrLow,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_memData,
    input  logic [DATA_W-1:0] in_pcPlus4,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    output logic              regWrite,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] writeData,
    output logic              fwdA,
    output logic              fwdB,
    output logic              wbValid,
    output logic [31:0]       retireCount
);
    logic              valid_r;
    logic              regwrite_r;
    logic [4:0]        rd_r;
    logic [1:0]        wbsel_r;
    logic [1:0]        memsize_r;
    logic              memunsigned_r;
    logic [1:0]        addrlow_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] mem_r;
    logic [DATA_W-1:0] pc4_r;
    logic [31:0]       retire_cnt;
    logic [DATA_W-1:0] mem_shift;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [DATA_W-1:0] load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r       <= 1'b0;
            regwrite_r    <= 1'b0;
            rd_r          <= '0;
            wbsel_r       <= '0;
            memsize_r     <= '0;
            memunsigned_r <= 1'b0;
            addrlow_r     <= '0;
            alu_r         <= '0;
            mem_r         <= '0;
            pc4_r         <= '0;
            retire_cnt    <= '0;
        end else begin
            // The WB entry retires this cycle unless it is being held.
            if (valid_r && !stall)
                retire_cnt <= retire_cnt + 32'd1;
            if (flush)
                valid_r <= 1'b0;
            else if (!stall) begin
                valid_r       <= in_valid;
                regwrite_r    <= in_regWrite;
                rd_r          <= in_rd;
                wbsel_r       <= in_wbSel;
                memsize_r     <= in_memSize;
                memunsigned_r <= in_memUnsigned;
                addrlow_r     <= in_addrLow;
                alu_r         <= in_aluResult;
                mem_r         <= in_memData;
                pc4_r         <= in_pcPlus4;
            end
        end
    end

    always_comb begin
        mem_shift = mem_r >> {addrlow_r, 3'b000};
        byte_val  = mem_shift[7:0];
        half_val  = addrlow_r[1] ? mem_r[31:16] : mem_r[15:0];
        load_val  = memsize_r[1] ? mem_r :
                    memsize_r[0] ? {{16{~memunsigned_r & half_val[15]}}, half_val} :
                                   {{24{~memunsigned_r & byte_val[7]}}, byte_val};
        writeData = wbsel_r == 2'b01 ? load_val :
                    wbsel_r == 2'b10 ? pc4_r + 32'd4 : alu_r;
        regWrite  = valid_r & regwrite_r & (rd_r != 5'd0);
        rd        = rd_r;
        fwdA      = regWrite & (rd_r == rs);
        fwdB      = regWrite & (rd_r == rt);
        wbValid   = valid_r;
    end

    assign retireCount = retire_cnt;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with hand-computed expectations for writeback_stage.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_regWrite, in_memUnsigned;
    logic [4:0]  in_rd, rs, rt;
    logic [1:0]  in_wbSel, in_memSize, in_addrLow;
    logic [31:0] in_aluResult, in_memData, in_pcPlus4;
    logic        regWrite, fwdA, fwdB, wbValid;
    logic [4:0]  rd;
    logic [31:0] writeData, retireCount;
    int          n_checks = 0;
    int          n_pass = 0;

    writeback_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regWrite(in_regWrite), .in_rd(in_rd),
        .in_wbSel(in_wbSel), .in_memSize(in_memSize), .in_memUnsigned(in_memUnsigned),
        .in_addrLow(in_addrLow), .in_aluResult(in_aluResult), .in_memData(in_memData),
        .in_pcPlus4(in_pcPlus4), .rs(rs), .rt(rt),
        .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .fwdA(fwdA), .fwdB(fwdB), .wbValid(wbValid), .retireCount(retireCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] r, input logic [1:0] sel,
                         input logic [1:0] size, input logic uns, input logic [1:0] al,
                         input logic [31:0] alu, input logic [31:0] md, input logic [31:0] pc);
        in_valid = v; in_regWrite = rw; in_rd = r; in_wbSel = sel; in_memSize = size;
        in_memUnsigned = uns; in_addrLow = al; in_aluResult = alu; in_memData = md; in_pcPlus4 = pc;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; rs = 5'd0; rt = 5'd0;
        drive(1, 1, 5'd9, 2'b00, 2'b10, 0, 2'd0, 32'hA5A5A5A5, 32'h0, 32'h0);
        step; step;
        check("reset_regWrite", {31'd0, regWrite}, 32'd0);
        check("reset_writeData", writeData, 32'd0);
        check("reset_count", retireCount, 32'd0);
        rst = 1'b0;
        step;
        check("pre_async_wd", writeData, 32'hA5A5A5A5);
        // Async reset between clock edges must clear outputs immediately.
        rst = 1'b1; #1;
        check("async_rst_rw", {31'd0, regWrite}, 32'd0);
        check("async_rst_valid", {31'd0, wbValid}, 32'd0);
        check("async_rst_rd", {27'd0, rd}, 32'd0);
        check("async_rst_wd", writeData, 32'd0);
        check("async_rst_fwd", {30'd0, fwdA, fwdB}, 32'd0);
        rst = 1'b0;

        drive(1, 1, 5'd5, 2'b01, 2'b00, 0, 2'd1, 32'h0, 32'h123480FF, 32'h0);
        step;
        check("lb_signed", writeData, 32'hFFFFFF80);
        check("lb_regWrite", {31'd0, regWrite}, 32'd1);
        check("lb_rd", {27'd0, rd}, 32'd5);
        drive(1, 1, 5'd5, 2'b01, 2'b00, 1, 2'd1, 32'h0, 32'h123480FF, 32'h0);
        step;
        check("lbu", writeData, 32'h00000080);
        drive(1, 1, 5'd6, 2'b01, 2'b01, 1, 2'd2, 32'h0, 32'h1234ABCD, 32'h0);
        step;
        check("lhu_hi", writeData, 32'h00001234);
        drive(1, 1, 5'd6, 2'b01, 2'b01, 0, 2'd1, 32'h0, 32'h1234ABCD, 32'h0);
        step;
        check("lh_lo_signed", writeData, 32'hFFFFABCD);
        drive(1, 1, 5'd6, 2'b01, 2'b10, 0, 2'd3, 32'h0, 32'hCAFEF00D, 32'h0);
        step;
        check("lw", writeData, 32'hCAFEF00D);
        drive(1, 1, 5'd31, 2'b10, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h00400008);
        step;
        check("link", writeData, 32'h0040000C);
        drive(1, 1, 5'd8, 2'b11, 2'b00, 0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        step;
        check("sel11_alu", writeData, 32'hDEADBEEF);

        drive(1, 1, 5'd0, 2'b00, 2'b00, 0, 2'd0, 32'h1, 32'h0, 32'h0);
        step;
        check("r0_regWrite", {31'd0, regWrite}, 32'd0);
        check("r0_fwd", {30'd0, fwdA, fwdB}, 32'd0);
        drive(1, 1, 5'd7, 2'b00, 2'b00, 0, 2'd0, 32'h77, 32'h0, 32'h0);
        rs = 5'd7; rt = 5'd3;
        step;
        check("fwd_a_only", {30'd0, fwdA, fwdB}, 32'b10);
        rt = 5'd7; #1;
        check("fwd_both", {30'd0, fwdA, fwdB}, 32'b11);
        drive(1, 0, 5'd7, 2'b00, 2'b00, 0, 2'd0, 32'h77, 32'h0, 32'h0);
        step;
        check("fwd_no_write", {30'd0, fwdA, fwdB}, 32'd0);
        drive(0, 1, 5'd7, 2'b00, 2'b00, 0, 2'd0, 32'h77, 32'h0, 32'h0);
        step;
        check("bubble_rw", {31'd0, regWrite}, 32'd0);
        rs = 5'd0; rt = 5'd0;

        rst = 1'b1; #1; rst = 1'b0;
        check("cnt_cleared", retireCount, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 5'(i), 2'b00, 2'b00, 0, 2'd0, 32'(i * 'h11), 32'h0, 32'h0);
            step;
        end
        check("cnt_after3", retireCount, 32'd2);
        check("i3_wd", writeData, 32'h33);
        stall = 1'b1;
        drive(1, 1, 5'd9, 2'b00, 2'b00, 0, 2'd0, 32'h99, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step;
            check("stall_wd", writeData, 32'h33);
            check("stall_rd", {27'd0, rd}, 32'd3);
            check("stall_rw", {31'd0, regWrite}, 32'd1);
            check("stall_cnt", retireCount, 32'd2);
        end
        stall = 1'b0; flush = 1'b1;
        step;
        check("flush_cnt", retireCount, 32'd3);
        check("flush_valid", {31'd0, wbValid}, 32'd0);
        check("flush_rw", {31'd0, regWrite}, 32'd0);
        flush = 1'b0;
        step;
        check("cap_after_flush", {31'd0, wbValid}, 32'd1);
        check("cnt_hold_bubble", retireCount, 32'd3);
        stall = 1'b1; flush = 1'b1;
        step;
        check("stall_flush_valid", {31'd0, wbValid}, 32'd0);
        check("stall_flush_cnt", retireCount, 32'd3);
        stall = 1'b0; flush = 1'b0;

        force dut.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        #1;
        check("preload", retireCount, 32'hFFFFFFFF);
        drive(1, 1, 5'd4, 2'b00, 2'b00, 0, 2'd0, 32'h44, 32'h0, 32'h0);
        step;
        check("preload_hold", retireCount, 32'hFFFFFFFF);
        drive(1, 1, 5'd4, 2'b00, 2'b00, 0, 2'd0, 32'h45, 32'h0, 32'h0);
        step;
        check("wrap", retireCount, 32'd0);
        step;
        check("after_wrap", retireCount, 32'd1);
        rst = 1'b1; #1;
        check("mid_rst_cnt", retireCount, 32'd0);
        check("mid_rst_rw", {31'd0, regWrite}, 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
